// File: rtl/control_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
// Shared definitions for the hardwired control sequencer:
//   - sequencer state encoding (IDLE, T0..T7, HALT)
//   - opcode constants and the opcode classifier
//   - ALU add select value
//   - IR field positions
//   - strobe bundle produced by the step decoder
// -----------------------------------------------------------------------------
package control_pkg;

   // ALU operation select that performs an add (address and immediate math).
   localparam logic [4:0] ADD_SEL = 5'b00011;

   // IR field positions.
   localparam int unsigned OP_MSB = 31;
   localparam int unsigned OP_LSB = 27;
   localparam int unsigned RA_MSB = 26;
   localparam int unsigned RA_LSB = 23;
   localparam int unsigned RB_MSB = 22;
   localparam int unsigned RB_LSB = 19;
   localparam int unsigned RC_MSB = 18;
   localparam int unsigned RC_LSB = 15;
   localparam int unsigned C_MSB  = 18;
   localparam int unsigned C_LSB  = 0;

   // Opcodes.
   localparam logic [4:0] OP_LD        = 5'b00000;
   localparam logic [4:0] OP_LDI       = 5'b00001;
   localparam logic [4:0] OP_ST        = 5'b00010;
   localparam logic [4:0] OP_ALU_FIRST = 5'b00011;  // add
   localparam logic [4:0] OP_ALU_LAST  = 5'b01011;
   localparam logic [4:0] OP_ADDI      = 5'b01100;
   localparam logic [4:0] OP_NOP       = 5'b11010;
   localparam logic [4:0] OP_HALT      = 5'b11011;

   typedef enum logic [3:0] {
      S_IDLE,
      S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
      S_HALT
   } state_t;

   typedef enum logic [2:0] {
      C_LD, C_LDI, C_ST, C_ALU, C_ADDI, C_NOP, C_HALT, C_ILLEGAL
   } op_class_t;

   // One bit per datapath strobe plus two sequencing hints:
   //   done     - this step ends the instruction
   //   mem_wait - this step is held until mem_ready
   typedef struct packed {
      logic pc_out;
      logic mdr_out;
      logic zlo_out;
      logic r_out;
      logic c_out;
      logic ba_out;
      logic mar_in;
      logic mdr_in;
      logic ir_in;
      logic pc_in;
      logic y_in;
      logic zlow_in;
      logic r_in;
      logic inc_pc;
      logic read;
      logic write;
      logic gra;
      logic grb;
      logic grc;
      logic halted;
      logic done;
      logic mem_wait;
   } strobes_t;

   function automatic op_class_t classify(input logic [4:0] op);
      if (op == OP_LD)   return C_LD;
      if (op == OP_LDI)  return C_LDI;
      if (op == OP_ST)   return C_ST;
      if (op >= OP_ALU_FIRST && op <= OP_ALU_LAST) return C_ALU;
      if (op == OP_ADDI) return C_ADDI;
      if (op == OP_NOP)  return C_NOP;
      if (op == OP_HALT) return C_HALT;
      return C_ILLEGAL;
   endfunction

   // Straight-line successor of an execute step; branching (waits, end of
   // instruction, halt) is handled by the sequencer.
   function automatic state_t next_step(input state_t s);
      case (s)
         S_T0:    return S_T1;
         S_T1:    return S_T2;
         S_T2:    return S_T3;
         S_T3:    return S_T4;
         S_T4:    return S_T5;
         S_T5:    return S_T6;
         S_T6:    return S_T7;
         default: return S_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/step_decoder.sv
// -----------------------------------------------------------------------------
// step_decoder
// Combinational map from (sequencer state, opcode) to the strobe vector.
// Ports:
//   state       - current sequencer state
//   opcode      - opcode of the instruction being sequenced
//   fetch_retry - 1 on the second and later cycles of a waiting T1
//   strb        - strobe bundle (datapath strobes + done/mem_wait hints)
//   op_sel      - ALU operation select
// -----------------------------------------------------------------------------
module step_decoder
   import control_pkg::*;
#(
   parameter int unsigned     OP_W    = 5,
   parameter logic [OP_W-1:0] ADD_SEL = control_pkg::ADD_SEL
) (
   input  state_t          state,
   input  logic [OP_W-1:0] opcode,
   input  logic            fetch_retry,
   output strobes_t        strb,
   output logic [OP_W-1:0] op_sel
);

   op_class_t cls;
   logic      mem_class;

   // NOTE: every output of a combinational block gets a default first, so
   // no path through the case statements can leave a value held (latch).
   always_comb begin
      strb      = '0;
      op_sel    = '0;
      cls       = classify(opcode);
      mem_class = (cls == C_LD) || (cls == C_ST);

      case (state)
         S_T0: begin
            strb.pc_out  = 1'b1;
            strb.mar_in  = 1'b1;
            strb.inc_pc  = 1'b1;
            strb.zlow_in = 1'b1;
         end
         S_T1: begin
            strb.zlo_out  = 1'b1;
            strb.read     = 1'b1;
            strb.mdr_in   = 1'b1;
            strb.mem_wait = 1'b1;
            // Incremented PC is loaded once, even if the fetch waits.
            strb.pc_in    = !fetch_retry;
         end
         S_T2: begin
            strb.mdr_out = 1'b1;
            strb.ir_in   = 1'b1;
            strb.done    = (cls == C_NOP);
         end
         S_T3: begin
            strb.grb    = 1'b1;
            strb.r_out  = 1'b1;
            strb.y_in   = 1'b1;
            // Base-address form: R0 as base reads as zero.
            strb.ba_out = mem_class || (cls == C_LDI);
         end
         S_T4: begin
            strb.zlow_in = 1'b1;
            if (cls == C_ALU) begin
               strb.grc  = 1'b1;
               strb.r_out = 1'b1;
               op_sel    = opcode;
            end else begin
               strb.c_out = 1'b1;
               op_sel     = ADD_SEL;
            end
         end
         S_T5: begin
            strb.zlo_out = 1'b1;
            if (mem_class) begin
               strb.mar_in = 1'b1;
            end else begin
               strb.gra  = 1'b1;
               strb.r_in = 1'b1;
               strb.done = 1'b1;
            end
         end
         S_T6: begin
            strb.mdr_in = 1'b1;
            if (cls == C_ST) begin
               strb.gra   = 1'b1;
               strb.r_out = 1'b1;
            end else begin
               strb.read     = 1'b1;
               strb.mem_wait = 1'b1;
            end
         end
         S_T7: begin
            strb.done = 1'b1;
            if (cls == C_ST) begin
               strb.write    = 1'b1;
               strb.mem_wait = 1'b1;
            end else begin
               strb.mdr_out = 1'b1;
               strb.gra     = 1'b1;
               strb.r_in    = 1'b1;
            end
         end
         S_HALT:  strb.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Hardwired control unit upstream of the datapath. Runs fetch (T0-T2), then
// sequences the execute steps of the latched opcode. Memory steps hold until
// mem_ready. An undefined opcode sets the sticky illegal flag and halts.
// Ports:
//   clk        - system clock, rising edge
//   clr        - asynchronous active-low reset
//   run        - level; 1 permits instruction issue
//   mem_ready  - memory acknowledge for Read/Write
//   ir         - IR contents from the datapath
//   PC_out .. BAout          - bus drivers
//   MARin .. Rin             - register loads
//   IncPC, Read, Write       - PC and memory control
//   Gra, Grb, Grc            - register field selects
//   op_sel                   - ALU operation
//   instr_done               - pulse in the final step of each instruction
//   halted                   - in HALT state
//   illegal                  - sticky, set on an undefined opcode
// -----------------------------------------------------------------------------
module control_sequencer #(
   parameter int unsigned     DATA_W  = 32,
   parameter int unsigned     OP_W    = 5,
   parameter logic [OP_W-1:0] ADD_SEL = control_pkg::ADD_SEL
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              run,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] ir,
   output logic              PC_out,
   output logic              MDR_out,
   output logic              Zlo_out,
   output logic              R_out,
   output logic              C_out,
   output logic              BAout,
   output logic              MARin,
   output logic              MDRin,
   output logic              IRin,
   output logic              PCin,
   output logic              Yin,
   output logic              Zlowin,
   output logic              Rin,
   output logic              IncPC,
   output logic              Read,
   output logic              Write,
   output logic              Gra,
   output logic              Grb,
   output logic              Grc,
   output logic [OP_W-1:0]   op_sel,
   output logic              instr_done,
   output logic              halted,
   output logic              illegal
);

   import control_pkg::*;

   state_t          state_q, state_d;
   logic [OP_W-1:0] op_q;
   logic            fetch_retry_q;
   logic            illegal_q;

   logic [OP_W-1:0] ir_op;
   logic [OP_W-1:0] dec_op;
   op_class_t       ir_cls;
   strobes_t        strb;
   logic            unused_ir_fields;

   assign ir_op  = ir[DATA_W-1 -: OP_W];
   assign ir_cls = classify(ir_op);
   // Register fields are consumed by the datapath's select-and-encode logic.
   assign unused_ir_fields = ^{ir[RA_MSB:RA_LSB], ir[RB_MSB:RB_LSB],
                               ir[RC_MSB:RC_LSB], ir[C_MSB:C_LSB]};

   // The latched copy only updates at the end of T2, so T2 itself (where a
   // nop ends) decodes the live IR field.
   assign dec_op = (state_q == S_T2) ? ir_op : op_q;

   step_decoder #(
      .OP_W    (OP_W),
      .ADD_SEL (ADD_SEL)
   ) u_step_decoder (
      .state       (state_q),
      .opcode      (dec_op),
      .fetch_retry (fetch_retry_q),
      .strb        (strb),
      .op_sel      (op_sel)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (run) state_d = S_T0;
         S_HALT: state_d = S_HALT;
         default: begin
            if (strb.mem_wait && !mem_ready) begin
               state_d = state_q;
            end else if (strb.done) begin
               state_d = run ? S_T0 : S_IDLE;
            end else if (state_q == S_T2 &&
                         (ir_cls == C_HALT || ir_cls == C_ILLEGAL)) begin
               state_d = S_HALT;
            end else begin
               state_d = next_step(state_q);
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q       <= S_IDLE;
         op_q          <= '0;
         fetch_retry_q <= 1'b0;
         illegal_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_retry_q <= (state_q == S_T1) && !mem_ready;
         if (state_q == S_T2) begin
            op_q <= ir_op;
            if (ir_cls == C_ILLEGAL) illegal_q <= 1'b1;
         end
      end
   end

   assign PC_out     = strb.pc_out;
   assign MDR_out    = strb.mdr_out;
   assign Zlo_out    = strb.zlo_out;
   assign R_out      = strb.r_out;
   assign C_out      = strb.c_out;
   assign BAout      = strb.ba_out;
   assign MARin      = strb.mar_in;
   assign MDRin      = strb.mdr_in;
   assign IRin       = strb.ir_in;
   assign PCin       = strb.pc_in;
   assign Yin        = strb.y_in;
   assign Zlowin     = strb.zlow_in;
   assign Rin        = strb.r_in;
   assign IncPC      = strb.inc_pc;
   assign Read       = strb.read;
   assign Write      = strb.write;
   assign Gra        = strb.gra;
   assign Grb        = strb.grb;
   assign Grc        = strb.grc;
   assign halted     = strb.halted;
   assign illegal    = illegal_q;
   // A waiting final step (st write) completes only on its acknowledged cycle.
   assign instr_done = strb.done && (!strb.mem_wait || mem_ready);

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

   typedef logic [26:0] obs_t;

   // Observation vector bit masks; op_sel occupies bits 4:0.
   localparam obs_t PCO  = obs_t'(1) << 26;
   localparam obs_t MDRO = obs_t'(1) << 25;
   localparam obs_t ZLOO = obs_t'(1) << 24;
   localparam obs_t RO   = obs_t'(1) << 23;
   localparam obs_t CO   = obs_t'(1) << 22;
   localparam obs_t BAO  = obs_t'(1) << 21;
   localparam obs_t MARI = obs_t'(1) << 20;
   localparam obs_t MDRI = obs_t'(1) << 19;
   localparam obs_t IRI  = obs_t'(1) << 18;
   localparam obs_t PCI  = obs_t'(1) << 17;
   localparam obs_t YI   = obs_t'(1) << 16;
   localparam obs_t ZLWI = obs_t'(1) << 15;
   localparam obs_t RI   = obs_t'(1) << 14;
   localparam obs_t INC  = obs_t'(1) << 13;
   localparam obs_t RD   = obs_t'(1) << 12;
   localparam obs_t WR   = obs_t'(1) << 11;
   localparam obs_t GRA  = obs_t'(1) << 10;
   localparam obs_t GRB  = obs_t'(1) << 9;
   localparam obs_t GRC  = obs_t'(1) << 8;
   localparam obs_t DONE = obs_t'(1) << 7;
   localparam obs_t HLT  = obs_t'(1) << 6;
   localparam obs_t ILL  = obs_t'(1) << 5;
   localparam obs_t ADDS = obs_t'(3);
   localparam obs_t ZERO = '0;

   localparam obs_t T0M  = PCO | MARI | INC | ZLWI;
   localparam obs_t T1F  = ZLOO | PCI | RD | MDRI;
   localparam obs_t T1W  = ZLOO | RD | MDRI;
   localparam obs_t T2M  = MDRO | IRI;
   localparam obs_t T3B  = GRB | BAO | RO | YI;
   localparam obs_t T3R  = GRB | RO | YI;
   localparam obs_t T4I  = CO | ZLWI | ADDS;
   localparam obs_t ADRM = ZLOO | MARI;
   localparam obs_t WBM  = ZLOO | GRA | RI | DONE;

   localparam logic [31:0] LD_IR   = 32'h0090_0065;
   localparam logic [31:0] ST_IR   = 32'h1180_0034;
   localparam logic [31:0] ADD_IR  = 32'h1A92_0000;
   localparam logic [31:0] NOP_IR  = 32'hD000_0000;
   localparam logic [31:0] HALT_IR = 32'hD800_0000;
   localparam logic [31:0] ILL_IR  = 32'hF800_0000;

   logic        clk = 1'b0;
   logic        clr, run, mem_ready;
   logic [31:0] ir;
   logic PC_out, MDR_out, Zlo_out, R_out, C_out, BAout;
   logic MARin, MDRin, IRin, PCin, Yin, Zlowin, Rin;
   logic IncPC, Read, Write, Gra, Grb, Grc;
   logic [4:0] op_sel;
   logic instr_done, halted, illegal;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   control_sequencer dut (
      .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .ir(ir),
      .PC_out(PC_out), .MDR_out(MDR_out), .Zlo_out(Zlo_out), .R_out(R_out),
      .C_out(C_out), .BAout(BAout), .MARin(MARin), .MDRin(MDRin),
      .IRin(IRin), .PCin(PCin), .Yin(Yin), .Zlowin(Zlowin), .Rin(Rin),
      .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb),
      .Grc(Grc), .op_sel(op_sel), .instr_done(instr_done),
      .halted(halted), .illegal(illegal)
   );

   function automatic obs_t sample();
      return {PC_out, MDR_out, Zlo_out, R_out, C_out, BAout, MARin, MDRin,
              IRin, PCin, Yin, Zlowin, Rin, IncPC, Read, Write, Gra, Grb, Grc,
              instr_done, halted, illegal, op_sel};
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %07h want %07h", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, compare shortly after.
   task automatic cyc(input logic r, input logic m, input logic [31:0] i,
                      input obs_t e, input string name);
      @(negedge clk);
      run = r; mem_ready = m; ir = i;
      #1;
      check(name, sample(), e);
   endtask

   task automatic clr_pulse(input string name);
      @(negedge clk);
      clr = 1'b0; run = 1'b0;
      #1;
      check(name, sample(), ZERO);
      @(negedge clk);
      clr = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        run;
      logic        mr;
      logic [31:0] ir;
      obs_t        exp;
      string       name;
   } vec_t;
   vec_t vecs[$];

   function automatic void add(logic r, logic m, logic [31:0] i, obs_t e, string n);
      vec_t v;
      v.run = r; v.mr = m; v.ir = i; v.exp = e; v.name = n;
      vecs.push_back(v);
   endfunction

   // ---------------- random reference model ----------------
   typedef struct {
      logic rn;
      logic mr;
      obs_t exp;
   } step_t;
   step_t sq[$];

   function automatic void push(obs_t e, logic mr);
      step_t s;
      s.rn = 1'($urandom); s.mr = mr; s.exp = e;
      sq.push_back(s);
   endfunction

   // Expected per-cycle strobes of one instruction from T0, with random wait
   // states on the fetch and on the data memory access.
   function automatic void model_instr(input logic [4:0] op);
      int w1 = $urandom_range(0, 2);
      int w2 = $urandom_range(0, 2);
      sq.delete();
      push(T0M, 1'($urandom));
      for (int i = 0; i <= w1; i++) push((i == 0) ? T1F : T1W, i == w1);
      push(T2M | ((op == 5'b11010) ? DONE : ZERO), 1'($urandom));
      if (op == 5'd0) begin
         push(T3B, 1'($urandom)); push(T4I, 1'($urandom)); push(ADRM, 1'($urandom));
         for (int i = 0; i < w2; i++) push(RD | MDRI, 1'b0);
         push(RD | MDRI, 1'b1);
         push(MDRO | GRA | RI | DONE, 1'($urandom));
      end else if (op == 5'd1) begin
         push(T3B, 1'($urandom)); push(T4I, 1'($urandom)); push(WBM, 1'($urandom));
      end else if (op == 5'd2) begin
         push(T3B, 1'($urandom)); push(T4I, 1'($urandom)); push(ADRM, 1'($urandom));
         push(GRA | RO | MDRI, 1'($urandom));
         for (int i = 0; i < w2; i++) push(WR, 1'b0);
         push(WR | DONE, 1'b1);
      end else if (op >= 5'd3 && op <= 5'd11) begin
         push(T3R, 1'($urandom)); push(GRC | RO | ZLWI | obs_t'(op), 1'($urandom));
         push(WBM, 1'($urandom));
      end else if (op == 5'd12) begin
         push(T3R, 1'($urandom)); push(T4I, 1'($urandom)); push(WBM, 1'($urandom));
      end else if (op == 5'd27) begin
         push(HLT, 1'($urandom)); push(HLT, 1'($urandom));
      end else if (op != 5'd26) begin
         push(HLT | ILL, 1'($urandom)); push(HLT | ILL, 1'($urandom));
      end
   endfunction

   function automatic logic [4:0] pick_op();
      int r = $urandom_range(0, 19);
      logic [4:0] o;
      if (r <= 12) return 5'(r);
      if (r <= 14) return 5'd26;
      if (r == 15) return 5'd27;
      if (r == 16) begin
         do o = 5'($urandom_range(13, 31)); while (o == 5'd26 || o == 5'd27);
         return o;
      end
      return 5'($urandom_range(0, 2));
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0]  op;
      logic [31:0] cur_ir;
      logic        halting;

      // Reset with inputs active: everything must stay 0.
      clr = 1'b0; run = 1'b1; mem_ready = 1'b1; ir = 32'hFFFF_FFFF;
      @(negedge clk); #1;
      check("reset_outputs", sample(), ZERO);
      run = 1'b0;
      @(negedge clk);
      clr = 1'b1;

      for (int k = 0; k < 5; k++) add(0, 0, 32'h0, ZERO, "idle_run0");
      add(1, 0, 32'h0, ZERO, "idle_run1");
      // ld R1,0x65(R2), zero-wait memory
      add(1, 1, LD_IR, T0M, "ld_t0");
      add(1, 1, LD_IR, T1F, "ld_t1");
      add(1, 1, LD_IR, T2M, "ld_t2");
      add(1, 1, LD_IR, T3B, "ld_t3");
      add(1, 1, LD_IR, T4I, "ld_t4");
      add(1, 1, LD_IR, ADRM, "ld_t5");
      add(1, 1, LD_IR, RD | MDRI, "ld_t6");
      add(1, 1, LD_IR, MDRO | GRA | RI | DONE, "ld_t7");
      // add R5,R2,R4 back-to-back, fetch waits 3 cycles
      add(1, 0, ADD_IR, T0M, "add_t0");
      add(1, 0, ADD_IR, T1F, "add_t1_first");
      add(1, 0, ADD_IR, T1W, "add_t1_wait1");
      add(1, 0, ADD_IR, T1W, "add_t1_wait2");
      add(1, 1, ADD_IR, T1W, "add_t1_ack");
      add(1, 1, ADD_IR, T2M, "add_t2");
      add(1, 1, ADD_IR, T3R, "add_t3");
      add(1, 1, ADD_IR, GRC | RO | ZLWI | ADDS, "add_t4");
      add(1, 1, ADD_IR, WBM, "add_t5");
      // st 0x34,R3 with run dropped mid-instruction and 2 write waits
      add(1, 1, ST_IR, T0M, "st_t0");
      add(1, 1, ST_IR, T1F, "st_t1");
      add(1, 1, ST_IR, T2M, "st_t2");
      add(0, 1, ST_IR, T3B, "st_t3");
      add(0, 1, ST_IR, T4I, "st_t4");
      add(0, 1, ST_IR, ADRM, "st_t5");
      add(0, 1, ST_IR, GRA | RO | MDRI, "st_t6");
      add(0, 0, ST_IR, WR, "st_t7_wait1");
      add(0, 0, ST_IR, WR, "st_t7_wait2");
      add(0, 1, ST_IR, WR | DONE, "st_t7_ack");
      add(0, 0, ST_IR, ZERO, "st_then_idle");
      // nop completes at T2
      add(1, 1, NOP_IR, ZERO, "nop_idle");
      add(0, 1, NOP_IR, T0M, "nop_t0");
      add(0, 1, NOP_IR, T1F, "nop_t1");
      add(0, 1, NOP_IR, T2M | DONE, "nop_t2");
      add(0, 1, NOP_IR, ZERO, "nop_then_idle");

      foreach (vecs[k]) cyc(vecs[k].run, vecs[k].mr, vecs[k].ir, vecs[k].exp, vecs[k].name);

      // halt: HALT entered after T2, no illegal, run ignored
      cyc(1, 1, HALT_IR, ZERO, "halt_idle");
      cyc(0, 1, HALT_IR, T0M, "halt_t0");
      cyc(0, 1, HALT_IR, T1F, "halt_t1");
      cyc(0, 1, HALT_IR, T2M, "halt_t2");
      cyc(1, 1, HALT_IR, HLT, "halt_state");
      cyc(1, 1, HALT_IR, HLT, "halt_holds");
      clr_pulse("halt_clr");

      // undefined opcode: illegal sticky plus halted
      cyc(1, 1, ILL_IR, ZERO, "ill_idle");
      cyc(0, 1, ILL_IR, T0M, "ill_t0");
      cyc(0, 1, ILL_IR, T1F, "ill_t1");
      cyc(0, 1, ILL_IR, T2M, "ill_t2");
      cyc(1, 1, ILL_IR, HLT | ILL, "ill_state");
      clr_pulse("ill_clr");
      cyc(0, 1, ILL_IR, ZERO, "ill_cleared");

      // clr mid-cycle during a held Write drops it at once
      cyc(1, 1, ST_IR, ZERO, "stclr_idle");
      cyc(0, 1, ST_IR, T0M, "stclr_t0");
      cyc(0, 1, ST_IR, T1F, "stclr_t1");
      cyc(0, 1, ST_IR, T2M, "stclr_t2");
      cyc(0, 1, ST_IR, T3B, "stclr_t3");
      cyc(0, 1, ST_IR, T4I, "stclr_t4");
      cyc(0, 1, ST_IR, ADRM, "stclr_t5");
      cyc(0, 1, ST_IR, GRA | RO | MDRI, "stclr_t6");
      cyc(1, 0, ST_IR, WR, "stclr_t7");
      #2 clr = 1'b0; run = 1'b0;
      #1 check("stclr_write_drop", sample(), ZERO);
      @(negedge clk);
      clr = 1'b1;
      cyc(0, 0, ST_IR, ZERO, "stclr_after");

      // randomized instruction stream against the reference model
      cyc(1, 0, 32'h0, ZERO, "rand_start");
      for (int n = 0; n < 60; n++) begin
         op      = pick_op();
         cur_ir  = {op, 27'($urandom)};
         halting = (op == 5'd27) || (op >= 5'd13 && op != 5'd26);
         model_instr(op);
         foreach (sq[k]) cyc(sq[k].rn, sq[k].mr, cur_ir, sq[k].exp, "rand_step");
         if (halting) begin
            clr_pulse("rand_clr");
            cyc(1, 1'($urandom), cur_ir, ZERO, "rand_restart");
         end else if (!sq[sq.size()-1].rn) begin
            cyc(1, 1'($urandom), cur_ir, ZERO, "rand_idle");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that sits directly upstream of the datapath.
- Issues, cycle by cycle, the bus-drive, register-load, memory and select-and-encode strobes that the datapath bench drives by hand today.
- Runs fetch (T0–T2), then decodes the IR opcode (IR[31:27]) and sequences the execute steps for: ld, ldi, st, three-register ALU ops, addi, nop and halt.
- Memory strobes hold until the memory acknowledges.

Parameters:
- DATA_W, 32, IR width.
- OP_W, 5, opcode and op_sel width.
- ADD_SEL, 5'b00011, op_sel value that selects ALU add.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- run  in  1  level; 1 permits instruction issue.
- mem_ready  in  1  memory acknowledge for Read/Write.
- ir  in  DATA_W  IR contents from the datapath.
- PC_out, MDR_out, Zlo_out, R_out, C_out, BAout  out  1 each  bus drivers.
- MARin, MDRin, IRin, PCin, Yin, Zlowin, Rin  out  1 each  register loads.
- IncPC, Read, Write  out  1 each  PC and memory control.
- Gra, Grb, Grc  out  1 each  select-and-encode register field selects.
- op_sel  out  OP_W  ALU operation.
- instr_done  out  1  one-cycle pulse in the final step of each instruction.
- halted  out  1  in HALT state.
- illegal  out  1  sticky flag, set on an undefined opcode.

Behaviour:
- Reset: while clr=0, state=IDLE and every output is 0, including op_sel and illegal.
- Output type: all strobes are Moore outputs decoded from the registered state plus the latched opcode. Asserted strobes are exactly those listed per step; everything else is 0.
- IDLE: go to T0 when run=1, otherwise stay.
- T0: PC_out, MARin, IncPC, Zlowin.
- T1: Zlo_out, PCin, Read, MDRin.
  - Stay in T1 while mem_ready=0. PCin pulses only on the first T1 cycle; a wait-state counter flag prevents a second PC load.
- T2: MDR_out, IRin. The opcode is captured from ir on the following edge; T3 onward decodes the latched opcode.
- ld (00000):
  - T3: Grb, BAout, R_out, Yin.
  - T4: C_out, op_sel=ADD_SEL, Zlowin.
  - T5: Zlo_out, MARin.
  - T6: Read, MDRin; wait on mem_ready.
  - T7: MDR_out, Gra, Rin.
- ldi (00001): T3 and T4 as ld; T5: Zlo_out, Gra, Rin.
- st (00010):
  - T3 to T5 as ld.
  - T6: Gra, R_out, MDRin.
  - T7: Write; hold while mem_ready=0.
- ALU ops (00011 add through 01011):
  - T3: Grb, R_out, Yin.
  - T4: Grc, R_out, op_sel=opcode, Zlowin.
  - T5: Zlo_out, Gra, Rin.
- addi (01100): T3: Grb, R_out, Yin; T4: C_out, op_sel=ADD_SEL, Zlowin; T5: Zlo_out, Gra, Rin.
- nop (11010): complete at T2.
- halt (11011): after T2 go to HALT. HALT asserts halted and no strobes, and is left only via clr.
- Any other opcode: set illegal, go to HALT.
- Instruction end: instr_done is asserted in the last step (T2 for nop). The next state is T0 if run=1, else IDLE.
- run dropping mid-instruction: the instruction still completes.
- mem_ready=1 already in the first cycle of a wait step: the step lasts exactly 1 cycle.
- Latency, zero-wait memory: ld/st 8 cycles, ALU/ldi/addi 6 cycles, nop 3 cycles.
- clr asserted mid-instruction: immediate return to IDLE, all strobes 0 in the same delta; no partial Write survives.

Decomposition:
- Shared package control_pkg holds:
  - state encoding (IDLE, T0–T7, HALT);
  - opcode constants;
  - ADD_SEL;
  - IR field positions (ra 26:23, rb 22:19, rc 18:15, C 18:0).
- Sub-module step_decoder: combinational mapping of (state, opcode) to the strobe vector. The sequencer FSM and the wait/latch logic stay in the top module.

Test Plan:
- Reset and idle: clr=0 at mid-cycle, then release with run=0 for 5 cycles -> all outputs 0, state IDLE. Raise run -> T0 strobes on the next cycle.
- ld with zero-wait memory: ir=0x00900065 (ld R1,0x65(R2)), mem_ready=1 -> T3 Grb/BAout/R_out/Yin, T4 op_sel=00011, T7 MDR_out/Gra/Rin. instr_done in cycle 8.
- st with 2 wait states on write: ir=0x11800034 (st 0x34,R3), mem_ready low for 2 cycles in T7 -> Write held 3 cycles, Gra/R_out/MDRin in T6, instr_done on the last Write cycle.
- add: ir=0x1A920000 (add R5,R2,R4) -> T4 Grc/R_out/Zlowin with op_sel=00011, T5 Gra/Rin. Back-to-back with run=1 shows T0 immediately after.
- Fetch wait: mem_ready low 3 cycles in T1 -> PCin pulses once only, Read/MDRin held 4 cycles.
- halt and illegal: ir=0xD8000000 -> halted=1 after T2, illegal=0. After clr, ir=0xF8000000 -> illegal=1 and halted=1. clr clears both; clr asserted during st T7 drops Write asynchronously.
